// File: rtl/booth_seq.sv
// Operand sequencer for the booth multiplier core: accepts an operand pair,
// steps the core through WIDTH iterations and hands the product downstream.
module booth_seq #(
    parameter int WIDTH  = 4,
    parameter int CNT_W  = 3,
    parameter bit SIGNED = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic [2*WIDTH-1:0]   multiplicand,
    output logic [WIDTH-1:0]     multiplier,
    output logic [CNT_W-1:0]     count,
    output logic                 core_reset,
    input  logic [2*WIDTH-1:0]   result_out,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);

    state_t                state_r;
    logic                  in_ready_r;
    logic                  core_reset_r;
    logic                  busy_r;
    logic                  out_valid_r;
    logic [2*WIDTH-1:0]    multiplicand_r;
    logic [WIDTH-1:0]      multiplier_r;
    logic [CNT_W-1:0]      count_r;
    logic [2*WIDTH-1:0]    prod_r;
    logic [WIDTH-1:0]      ext_s;

    // Upper half of the multiplicand: sign copies or zeros.
    always_comb begin
        ext_s = {WIDTH{1'b0}};
        if (SIGNED) begin
            ext_s = {WIDTH{a_in[WIDTH-1]}};
        end else begin
            ext_s = {WIDTH{1'b0}};
        end
    end

    // Sequencer FSM; every output is a register updated alongside the state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r        <= IDLE;
            in_ready_r     <= 1'b0;
            core_reset_r   <= 1'b1;
            busy_r         <= 1'b0;
            out_valid_r    <= 1'b0;
            multiplicand_r <= {(2*WIDTH){1'b0}};
            multiplier_r   <= {WIDTH{1'b0}};
            count_r        <= CNT_ZERO;
            prod_r         <= {(2*WIDTH){1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    in_ready_r   <= 1'b1;
                    core_reset_r <= 1'b0;
                    busy_r       <= 1'b0;
                    // in_ready_r is still low on the first edge after reset release
                    if (in_valid && in_ready_r) begin
                        multiplier_r   <= b_in;
                        multiplicand_r <= {ext_s, a_in};
                        count_r        <= CNT_ZERO;
                        in_ready_r     <= 1'b0;
                        core_reset_r   <= 1'b1;
                        busy_r         <= 1'b1;
                        state_r        <= LOAD;
                    end
                end
                LOAD: begin
                    core_reset_r <= 1'b0;
                    count_r      <= CNT_ONE;
                    state_r      <= RUN;
                end
                RUN: begin
                    if (count_r == CNT_LAST) begin
                        prod_r      <= result_out;
                        out_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end else begin
                        count_r <= count_r + CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    state_r      <= IDLE;
                    in_ready_r   <= 1'b0;
                    core_reset_r <= 1'b1;
                    busy_r       <= 1'b0;
                    out_valid_r  <= 1'b0;
                    count_r      <= CNT_ZERO;
                end
            endcase
        end
    end

    assign in_ready     = in_ready_r;
    assign core_reset   = core_reset_r;
    assign busy         = busy_r;
    assign out_valid    = out_valid_r;
    assign multiplicand = multiplicand_r;
    assign multiplier   = multiplier_r;
    assign count        = count_r;
    assign prod         = prod_r;

endmodule

// File: tb/tb_booth_seq.sv
// Directed bench for booth_seq: unsigned and signed sequencers in lockstep,
// each driving a small radix-2 booth core model that supplies result_out.
module tb_booth_seq;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic       out_ready;
    logic [3:0] a_in;
    logic [3:0] b_in;

    logic       in_ready0, cr0, ov0, busy0;
    logic [7:0] mc0, ro0, prod0, acc0;
    logic [3:0] mp0;
    logic [2:0] cnt0;

    logic       in_ready1, cr1, ov1, busy1;
    logic [7:0] mc1, ro1, prod1, acc1;
    logic [3:0] mp1;
    logic [2:0] cnt1;

    int checks   = 0;
    int failures = 0;

    booth_seq #(.WIDTH(4), .CNT_W(3), .SIGNED(1'b0)) u0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
        .a_in(a_in), .b_in(b_in), .multiplicand(mc0), .multiplier(mp0),
        .count(cnt0), .core_reset(cr0), .result_out(ro0), .prod(prod0),
        .out_valid(ov0), .out_ready(out_ready), .busy(busy0)
    );

    booth_seq #(.WIDTH(4), .CNT_W(3), .SIGNED(1'b1)) u1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
        .a_in(a_in), .b_in(b_in), .multiplicand(mc1), .multiplier(mp1),
        .count(cnt1), .core_reset(cr1), .result_out(ro1), .prod(prod1),
        .out_valid(ov1), .out_ready(out_ready), .busy(busy1)
    );

    always #5 clk = ~clk;

    // Booth partial term contributed by step c (1..4), bit pair q[c-1], q[c-2].
    function automatic logic [7:0] booth_term(input logic [7:0] m, input logic [3:0] q,
                                              input logic [2:0] c);
        logic [7:0] sh;
        logic       qp;
        int         i;
        if (c == 3'd0 || c > 3'd4) return 8'd0;
        i  = int'(c) - 1;
        sh = m << i;
        qp = (i == 0) ? 1'b0 : q[i-1];
        case ({q[i], qp})
            2'b10:   return 8'd0 - sh;
            2'b01:   return sh;
            default: return 8'd0;
        endcase
    endfunction

    assign ro0 = acc0 + booth_term(mc0, mp0, cnt0);
    assign ro1 = acc1 + booth_term(mc1, mp1, cnt1);

    // Core accumulators, cleared while the sequencer holds core_reset.
    always @(posedge clk) begin
        if (cr0) acc0 <= 8'd0; else acc0 <= ro0;
        if (cr1) acc1 <= 8'd0; else acc1 <= ro1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] pa [4] = '{4'd2, 4'd7, 4'd15, 4'd9};
    logic [3:0] pb [4] = '{4'd3, 4'd5, 4'd7, 4'd6};
    logic [7:0] e0 [4] = '{8'd6, 8'd35, 8'd105, 8'd54};
    logic [7:0] e1 [4] = '{8'd6, 8'd35, 8'hF9, 8'hD6};

    initial begin
        int  lat;
        int  idx;
        int  got;
        int  last_t;
        logic acc_now;

        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_in = 4'd0; b_in = 4'd0;
        tick(); tick();
        check("rst_busy", 32'(busy0), 32'd0);
        check("rst_in_ready", 32'(in_ready0), 32'd0);
        check("rst_prod", 32'(prod0), 32'd0);
        check("rst_out_valid", 32'(ov0), 32'd0);
        check("rst_core_reset", 32'(cr0), 32'd1);
        check("rst_count", 32'(cnt0), 32'd0);
        check("rst_mcand", 32'(mc0), 32'd0);

        reset = 1'b1;
        in_valid = 1'b1; a_in = 4'd5; b_in = 4'd5;
        #1;
        check("rel_in_ready_pre", 32'(in_ready0), 32'd0);
        tick();
        check("rel_in_ready", 32'(in_ready0), 32'd1);
        check("rel_core_reset", 32'(cr0), 32'd0);
        check("rel_busy_no_accept", 32'(busy0), 32'd0);

        // Unsigned and signed 1011 x 0101
        a_in = 4'b1011; b_in = 4'b0101; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        check("load_count", 32'(cnt0), 32'd0);
        check("load_core_reset", 32'(cr0), 32'd1);
        check("load_in_ready", 32'(in_ready0), 32'd0);
        check("load_busy", 32'(busy0), 32'd1);
        check("mcand_unsigned", 32'(mc0), 32'h0B);
        check("mcand_signed", 32'(mc1), 32'hFB);
        check("mplier", 32'(mp0), 32'd5);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check("run_count", 32'(cnt0), 32'(k));
            check("run_core_reset", 32'(cr0), 32'd0);
            check("run_out_valid", 32'(ov0), 32'd0);
        end
        tick();
        check("done_out_valid", 32'(ov0), 32'd1);
        check("prod_unsigned", 32'(prod0), 32'h37);
        check("prod_signed", 32'(prod1), 32'hE7);
        check("done_count", 32'(cnt0), 32'd4);

        // Back-pressure in DONE with stray input pulses
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0]; a_in = 4'(k); b_in = 4'(k + 1);
            tick();
            check("hold_out_valid", 32'(ov0), 32'd1);
            check("hold_prod", 32'(prod0), 32'h37);
            check("hold_in_ready", 32'(in_ready0), 32'd0);
            check("hold_mplier", 32'(mp0), 32'd5);
            check("hold_count", 32'(cnt0), 32'd4);
        end

        // Simultaneous in_valid/out_ready in DONE: only the output transfer
        a_in = 4'd3; b_in = 4'd3; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("xfer_out_valid", 32'(ov0), 32'd0);
        check("xfer_in_ready", 32'(in_ready0), 32'd1);
        check("xfer_busy", 32'(busy0), 32'd0);
        tick();
        in_valid = 1'b0;
        check("late_accept_busy", 32'(busy0), 32'd1);
        check("late_accept_mplier", 32'(mp0), 32'd3);
        tick(); tick();
        check("abort_pre_count", 32'(cnt0), 32'd2);
        reset = 1'b0;
        #1;
        check("abort_out_valid", 32'(ov0), 32'd0);
        check("abort_count", 32'(cnt0), 32'd0);
        check("abort_core_reset", 32'(cr0), 32'd1);
        check("abort_busy", 32'(busy0), 32'd0);
        check("abort_prod", 32'(prod0), 32'd0);
        tick(); tick();
        reset = 1'b1;
        tick();
        a_in = 4'b0011; b_in = 4'b0011; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (ov0 !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        check("latency_edges", 32'(lat), 32'd5);
        check("prod_3x3", 32'(prod0), 32'd9);
        check("prod_3x3_signed", 32'(prod1), 32'd9);
        out_ready = 1'b1;
        tick();
        check("after_3x3_idle", 32'(busy0), 32'd0);

        // Four back-to-back operations with in_valid and out_ready held high
        idx = 0; got = 0; last_t = -1;
        in_valid = 1'b1; a_in = pa[0]; b_in = pb[0];
        for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
            acc_now = in_valid && in_ready0;
            tick();
            if (acc_now) begin
                idx++;
                if (idx < 4) begin
                    a_in = pa[idx]; b_in = pb[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (ov0 === 1'b1) begin
                check("stream_prod", 32'(prod0), 32'(e0[got]));
                check("stream_prod_signed", 32'(prod1), 32'(e1[got]));
                if (got > 0) check("stream_spacing", 32'(cyc - last_t), 32'd7);
                last_t = cyc;
                got++;
            end
        end
        check("stream_count", 32'(got), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/booth_seq.md
Name: booth_seq

Overview:
- Operand sequencer that sits directly upstream of the booth multiplier core and owns its control inputs.
- Accepts one operand pair per transaction on a valid/ready input handshake and drives the core's multiplicand, multiplier, step count and core reset.
- Captures the core's result_out after WIDTH steps and presents the product on a valid/ready output handshake.
- Replaces the hand-driven count/reset sequencing with a reusable, back-pressurable controller.

Parameters:
- WIDTH, 4: multiplier width; multiplicand and product are 2*WIDTH bits.
- CNT_W, 3: width of the count output; must satisfy 2^CNT_W > WIDTH.
- SIGNED, 0: 0 zero-extends a_in into multiplicand; 1 sign-extends it.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair a_in/b_in is valid.
- in_ready  output  1  sequencer can accept an operand pair.
- a_in  input  WIDTH  raw multiplicand operand.
- b_in  input  WIDTH  multiplier operand.
- multiplicand  output  2*WIDTH  to core: extended a_in.
- multiplier  output  WIDTH  to core: registered b_in.
- count  output  CNT_W  to core: current step index.
- core_reset  output  1  to core: active-high core clear.
- result_out  input  2*WIDTH  from core: running product.
- prod  output  2*WIDTH  captured product.
- out_valid  output  1  prod is valid.
- out_ready  input  1  downstream accepts prod.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset low, asynchronous):
  - state=IDLE; multiplicand=0, multiplier=0, count=0, prod=0.
  - out_valid=0, in_ready=0 while reset is low.
  - core_reset=1: the core is held cleared.
- Reset release: first clock edge after reset goes high leaves state IDLE with in_ready=1 and core_reset=0.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - in_ready=1, busy=0, core_reset=0.
  - Handshake: on an edge with in_valid=1, latch multiplier<=b_in and multiplicand<={ext,a_in}.
  - ext is all zeros when SIGNED=0, or WIDTH copies of a_in[WIDTH-1] when SIGNED=1.
  - Then count<=0 and go to LOAD.
- LOAD (exactly one cycle): core_reset=1, count=0. Next: count<=1, go to RUN.
- RUN:
  - core_reset=0.
  - count increments by 1 each cycle, starting at 1.
  - On the edge that ends the cycle with count==WIDTH: prod<=result_out, out_valid<=1, go to DONE.
  - count never wraps; WIDTH steps per operation.
- DONE:
  - out_valid=1; prod, multiplicand and multiplier are held stable.
  - count holds at WIDTH.
  - On an edge with out_ready=1: out_valid<=0, go to IDLE.
- Latency: accept edge T → out_valid high from the cycle after edge T+WIDTH+1, i.e. WIDTH+2 cycles. Throughput: one operation per WIDTH+3 cycles minimum.
- in_ready=0 in LOAD/RUN/DONE. in_valid and operand changes in those states are ignored; no pair is lost or latched.
- out_ready while out_valid=0 has no effect.
- Simultaneous in_valid and out_ready in DONE: only the output transfer occurs; the new pair is accepted in IDLE on a later edge.
- Reset asserted mid-LOAD/RUN/DONE aborts the operation immediately. All outputs take their reset values, including out_valid=0 and core_reset=1. No partial prod is presented.
- multiplicand, multiplier and count are registered outputs: no combinational path from a_in/b_in.

Test Plan:
- SIGNED=0, a_in=4'b1011, b_in=4'b0101 → multiplicand=8'b00001011; count trace 0,1,2,3,4; out_valid after 6 cycles; prod=8'b00110111 (55).
- SIGNED=1, a_in=4'b1011, b_in=4'b0101 → multiplicand=8'b11111011; prod=8'b11100111 (-25).
- Hold out_ready=0 for 5 cycles in DONE → prod and out_valid stay stable, in_ready=0, in_valid pulses ignored; out_ready=1 → IDLE next edge.
- Assert reset low while count=2 → immediately out_valid=0, count=0, core_reset=1. After release, operands 4'b0011 x 4'b0011 → prod=8'd9.
- Hold in_valid high with 4 different pairs and out_ready=1 → exactly 4 products in order, each WIDTH+3 cycles apart.
- Reset low → busy=0, in_ready=0, prod=0; first edge after release → in_ready=1, core_reset=0.
